// File: rtl/srf_pkg.sv
// Shared constants for the scoreboarded register file.
// Defaults for data width, index width and read-port count.
package srf_pkg;

    localparam int SRF_DBITS = 32;
    localparam int SRF_ABITS = 4;
    localparam int SRF_NRD   = 2;

    function automatic int srf_words(input int abits);
        return 1 << abits;
    endfunction

    localparam int SRF_WORDS = srf_words(SRF_ABITS);

endpackage

// File: rtl/srf_busy_scoreboard.sv
// Busy bit per register for multi-cycle producers, plus a
// registered population count of the busy vector.
module srf_busy_scoreboard
    import srf_pkg::*;
#(
    parameter int ABITS    = SRF_ABITS,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issEn,
    input  logic [ABITS-1:0]           issInd,
    input  logic                       wrtEn,
    input  logic [ABITS-1:0]           wrtInd,
    output logic [srf_words(ABITS)-1:0] busy,
    output logic [ABITS:0]             busyCnt
);

    localparam int WORDS = srf_words(ABITS);
    localparam logic [ABITS:0] ONE = {{ABITS{1'b0}}, 1'b1};

    logic             set_ok;
    logic             clr_ok;
    logic             inc;
    logic             dec;
    logic [WORDS-1:0] busy_nxt;

    assign set_ok = issEn && !((ZERO_REG != 0) && (issInd == '0));
    // A same-index issue overrides the clear: the new producer is pending.
    assign clr_ok = wrtEn && !(set_ok && (issInd == wrtInd));
    assign inc    = set_ok && !busy[issInd];
    assign dec    = clr_ok && busy[wrtInd];

    always_comb begin
        busy_nxt = busy;
        if (clr_ok) busy_nxt[wrtInd] = 1'b0;
        if (set_ok) busy_nxt[issInd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= '0;
            busyCnt <= '0;
        end else begin
            busy <= busy_nxt;
            unique case ({inc, dec})
                2'b10:   busyCnt <= busyCnt + ONE;
                2'b01:   busyCnt <= busyCnt - ONE;
                default: busyCnt <= busyCnt;
            endcase
        end
    end

endmodule

// File: rtl/scoreboard_reg_file.sv
// Multi-port register file with write bypass, optional zero
// register and a busy scoreboard driving the pipeline stall.
module scoreboard_reg_file
    import srf_pkg::*;
#(
    parameter int DBITS    = SRF_DBITS,
    parameter int ABITS    = SRF_ABITS,
    parameter int NRD      = SRF_NRD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrtEn,
    input  logic [ABITS-1:0]     wrtInd,
    input  logic [DBITS-1:0]     dIn,
    input  logic [NRD*ABITS-1:0] rdInd,
    input  logic [NRD-1:0]       rdUse,
    output logic [NRD*DBITS-1:0] dOut,
    input  logic                 issEn,
    input  logic [ABITS-1:0]     issInd,
    output logic [NRD-1:0]       rdBusy,
    output logic                 stall,
    output logic [ABITS:0]       busyCnt
);

    localparam int WORDS = srf_words(ABITS);

    logic [DBITS-1:0] regs [WORDS];
    logic [WORDS-1:0] busy;
    logic             wr_ok;

    // Reset also suppresses bypass so outputs read zero while held.
    assign wr_ok = wrtEn && !reset
                && !((ZERO_REG != 0) && (wrtInd == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wrtInd] <= dIn;
        end
    end

    srf_busy_scoreboard #(
        .ABITS    (ABITS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .issEn   (issEn),
        .issInd  (issInd),
        .wrtEn   (wrtEn),
        .wrtInd  (wrtInd),
        .busy    (busy),
        .busyCnt (busyCnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ABITS-1:0] idx;
        logic             zero;
        logic             hit;

        assign idx  = rdInd[k*ABITS +: ABITS];
        assign zero = (ZERO_REG != 0) && (idx == '0);
        assign hit  = (BYPASS != 0) && wr_ok && (wrtInd == idx);

        assign dOut[k*DBITS +: DBITS] = zero ? '0
                                      : hit  ? dIn
                                      : regs[idx];
        assign rdBusy[k] = busy[idx] && !zero && !hit;
    end

    assign stall = |(rdUse & rdBusy);

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Random and directed bench for scoreboard_reg_file, comparing a
// bypassing and a non-bypassing instance against a reference model.
module tb_scoreboard_reg_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wrtEn = 1'b0;
    logic [3:0]  wrtInd = '0;
    logic [31:0] dIn = '0;
    logic [7:0]  rdInd = '0;
    logic [1:0]  rdUse = '0;
    logic        issEn = 1'b0;
    logic [3:0]  issInd = '0;

    logic [63:0] dout_a, dout_b;
    logic [1:0]  busy_a, busy_b;
    logic        stall_a, stall_b;
    logic [4:0]  cnt_a, cnt_b;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    scoreboard_reg_file #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .wrtEn(wrtEn), .wrtInd(wrtInd),
        .dIn(dIn), .rdInd(rdInd), .rdUse(rdUse), .dOut(dout_a),
        .issEn(issEn), .issInd(issInd), .rdBusy(busy_a),
        .stall(stall_a), .busyCnt(cnt_a)
    );

    scoreboard_reg_file #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .wrtEn(wrtEn), .wrtInd(wrtInd),
        .dIn(dIn), .rdInd(rdInd), .rdUse(rdUse), .dOut(dout_b),
        .issEn(issEn), .issInd(issInd), .rdBusy(busy_b),
        .stall(stall_b), .busyCnt(cnt_b)
    );

    typedef struct {
        logic [63:0] da, db;
        logic [1:0]  ba, bb;
        logic        sa, sb;
        logic [4:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: register contents and busy flags.
    logic [31:0] mregs [16];
    bit          mbusy [16];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("dout_byp",   64'(dout_a),  e.da);
            chk("dout_nobyp", 64'(dout_b),  e.db);
            chk("busy_byp",   64'(busy_a),  64'(e.ba));
            chk("busy_nobyp", 64'(busy_b),  64'(e.bb));
            chk("stall_byp",  64'(stall_a), 64'(e.sa));
            chk("stall_nobyp",64'(stall_b), 64'(e.sb));
            chk("cnt_byp",    64'(cnt_a),   64'(e.cnt));
            chk("cnt_nobyp",  64'(cnt_b),   64'(e.cnt));
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        int   n;
        e.da = '0; e.db = '0; e.ba = '0; e.bb = '0;
        n = 0;
        for (int i = 0; i < 16; i++) if (mbusy[i]) n++;
        e.cnt = 5'(n);
        for (int k = 0; k < 2; k++) begin
            int          idx;
            bit          zero, hit;
            logic [31:0] stored;
            idx  = int'(rdInd[k*4 +: 4]);
            zero = (idx == 0);
            hit  = !reset && wrtEn && (int'(wrtInd) == idx) && (wrtInd != 0);
            stored = zero ? 32'h0 : mregs[idx];
            e.da[k*32 +: 32] = (hit && !zero) ? dIn : stored;
            e.db[k*32 +: 32] = stored;
            e.ba[k] = !zero && !hit && mbusy[idx];
            e.bb[k] = !zero && mbusy[idx];
        end
        e.sa = |(rdUse & e.ba);
        e.sb = |(rdUse & e.bb);
        return e;
    endfunction

    task automatic step(input bit r, input bit we, input logic [3:0] wi,
                        input logic [31:0] din, input logic [3:0] r0,
                        input logic [3:0] r1, input logic [1:0] u,
                        input bit ie, input logic [3:0] ii);
        @(posedge clk);
        #1;
        if (!reset) begin
            if (wrtEn && wrtInd != 0) mregs[wrtInd] = dIn;
            if (wrtEn) mbusy[wrtInd] = 1'b0;
            if (issEn && issInd != 0) mbusy[issInd] = 1'b1;
        end
        reset  = r;
        wrtEn  = we;
        wrtInd = wi;
        dIn    = din;
        rdInd  = {r1, r0};
        rdUse  = u;
        issEn  = ie;
        issInd = ii;
        if (r) model_clear();
        exp_q.push_back(predict());
    endtask

    task automatic rnd_step(input bit r);
        step(r, 1'($urandom), 4'($urandom), $urandom,
             4'($urandom), 4'($urandom), 2'($urandom),
             1'($urandom), 4'($urandom));
    endtask

    initial begin
        model_clear();
        repeat (4) rnd_step(1'b1);
        for (int i = 0; i < 16; i += 2)
            step(0, 0, 0, 0, 4'(i), 4'(i + 1), 2'b11, 0, 0);

        step(0, 1, 5, 32'hDEADBEEF, 5, 5, 0, 0, 0);
        step(0, 0, 0, 0, 5, 5, 0, 0, 0);
        step(1, 0, 0, 0, 5, 5, 0, 0, 0);
        step(0, 0, 0, 0, 5, 5, 0, 0, 0);

        step(0, 1, 0, 32'h12345678, 0, 0, 2'b11, 0, 0);
        step(0, 0, 0, 0, 0, 0, 2'b11, 1, 0);
        step(0, 0, 0, 0, 0, 0, 2'b11, 0, 0);

        step(0, 1, 3, 32'h11, 0, 0, 0, 0, 0);
        step(0, 1, 3, 32'h22, 3, 0, 2'b01, 0, 0);
        step(0, 0, 0, 0, 3, 0, 2'b01, 0, 0);

        step(0, 0, 0, 0, 0, 0, 0, 1, 7);
        step(0, 0, 0, 0, 0, 7, 2'b10, 0, 0);
        step(0, 1, 7, 32'h77, 0, 7, 2'b10, 0, 0);
        step(0, 0, 0, 0, 0, 7, 2'b10, 0, 0);

        step(0, 0, 0, 0, 9, 4, 2'b11, 1, 9);
        step(0, 1, 9, 32'h99, 9, 4, 2'b11, 1, 9);
        step(0, 1, 9, 32'h98, 9, 4, 2'b11, 1, 4);
        step(0, 0, 0, 0, 9, 4, 2'b11, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 1; i < 16; i++)
            step(0, 0, 0, 0, 4'(i), 4'(i - 1), 2'b11, 1, 4'(i));
        step(0, 0, 0, 0, 15, 1, 2'b11, 1, 15);
        for (int i = 1; i < 16; i++)
            step(0, 1, 4'(i), $urandom, 4'(i), 4'(16 - i), 2'b11, 0, 0);
        step(0, 0, 0, 0, 1, 2, 2'b11, 0, 0);

        for (int n = 0; n < 2000; n++)
            rnd_step($urandom_range(0, 199) == 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if (exp_q.size() != 0) begin
            miss++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
